pico_rx: RTL and testbench

- Serial-in receiver for the SPI peripheral; the inbound (PICO) counterpart of the readout path.
- Deserialises command bytes from the controller and decodes the address/RW byte.
- Owns the three writable registers (addr 1 trigger_channel_mask, addr 2 instruction, addr 3 mode).
- Drives the readout mux select (control_signal) and the byte-boundary strobe (msg_flag) that loads the serial output register.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/s2p_register.sv | 33 +++
 rtl/pico_rx.sv | 97 +++++++++
 tb/tb_pico_rx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral: register map, receiver states
// and the address auto-increment rule.
package spi_pkg;

  localparam logic [7:0] ADDR_RESERVED = 8'd0;
  localparam logic [7:0] ADDR_MASK     = 8'd1;
  localparam logic [7:0] ADDR_INSTR    = 8'd2;
  localparam logic [7:0] ADDR_MODE     = 8'd3;
  localparam int         NUM_REGS      = 59;
  localparam int         WR_BIT        = 7;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } rx_state_t;

  // Address 0 is reserved, so the wrap from the last register lands on 1.
  function automatic logic [7:0] next_addr(input logic [7:0] addr, input logic [7:0] last);
    return (addr == last) ? ADDR_MASK : addr + 8'd1;
  endfunction

endpackage

// File: rtl/s2p_register.sv
// LSB-first serial-to-parallel shifter with a 3-bit bit counter. byte_valid is
// high during the edge that clocks in the eighth bit; byte_data is that byte.
module s2p_register (
  input  logic       sclk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       din,
  output logic [7:0] byte_data,
  output logic       byte_valid
);

  // Bit 0 of the shifter would only ever hold a bit already shifted past the
  // byte boundary, so just bits [7:1] are kept.
  logic [7:1] shift;
  logic [2:0] bit_cnt;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (cs_n) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else begin
      shift   <= {din, shift[7:2]};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign byte_data  = {din, shift[7:1]};
  assign byte_valid = !cs_n && (bit_cnt == 3'd7);

endmodule

// File: rtl/pico_rx.sv
// SPI inbound receiver: decodes the address/RW byte, owns the writable
// registers and drives the readout mux select and byte-boundary strobe.
module pico_rx
  import spi_pkg::*;
#(
  parameter logic [7:0] MASK_RST  = 8'h00,
  parameter logic [7:0] INSTR_RST = 8'h00,
  parameter logic [7:0] MODE_RST  = 8'h00,
  parameter int         NUM_REGS  = spi_pkg::NUM_REGS
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       pico,
  output logic [7:0] control_signal,
  output logic       msg_flag,
  output logic [7:0] trigger_channel_mask,
  output logic [7:0] instruction,
  output logic [7:0] mode,
  output logic       wr_strobe,
  output logic       addr_err
);

  localparam logic [7:0] LAST_ADDR = 8'(NUM_REGS);

  logic [7:0] byte_data;
  logic       byte_valid;
  rx_state_t  state;
  logic       wr_mode;

  s2p_register u_s2p (
    .sclk       (sclk),
    .rst        (rst),
    .cs_n       (cs_n),
    .din        (pico),
    .byte_data  (byte_data),
    .byte_valid (byte_valid)
  );

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      wr_mode              <= 1'b0;
      control_signal       <= ADDR_RESERVED;
      msg_flag             <= 1'b0;
      wr_strobe            <= 1'b0;
      addr_err             <= 1'b0;
      trigger_channel_mask <= MASK_RST;
      instruction          <= INSTR_RST;
      mode                 <= MODE_RST;
    end else begin
      msg_flag  <= 1'b0;
      wr_strobe <= 1'b0;
      if (cs_n) begin
        // Abort: registers, address and error flag are deliberately kept.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= ADDR;
          ADDR: begin
            if (byte_valid) begin
              control_signal <= {1'b0, byte_data[6:0]};
              wr_mode        <= byte_data[WR_BIT];
              msg_flag       <= 1'b1;
              state          <= DATA;
            end
          end
          DATA: begin
            if (byte_valid) begin
              if (wr_mode) begin
                case (control_signal)
                  ADDR_MASK: begin
                    trigger_channel_mask <= byte_data;
                    wr_strobe            <= 1'b1;
                  end
                  ADDR_INSTR: begin
                    instruction <= byte_data;
                    wr_strobe   <= 1'b1;
                  end
                  ADDR_MODE: begin
                    mode      <= byte_data;
                    wr_strobe <= 1'b1;
                  end
                  default: addr_err <= 1'b1;
                endcase
              end
              control_signal <= next_addr(control_signal, LAST_ADDR);
              msg_flag       <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pico_rx.sv
// Randomised and directed checks of pico_rx against a transaction-level model
// of the register map and address sequencing.
module tb_pico_rx;

  localparam logic [7:0] MASK_RST  = 8'h5A;
  localparam logic [7:0] INSTR_RST = 8'hC3;
  localparam logic [7:0] MODE_RST  = 8'h07;
  localparam int         LAST      = 59;

  logic       sclk = 1'b0;
  logic       rst  = 1'b1;
  logic       cs_n = 1'b1;
  logic       pico = 1'b0;
  logic [7:0] control_signal, trigger_channel_mask, instruction, mode;
  logic       msg_flag, wr_strobe, addr_err;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [7:0] m_mask, m_instr, m_mode, m_addr;
  logic       m_err, m_wr, exp_msg, exp_wr;
  int         m_idx;

  pico_rx #(
    .MASK_RST  (MASK_RST),
    .INSTR_RST (INSTR_RST),
    .MODE_RST  (MODE_RST),
    .NUM_REGS  (LAST)
  ) dut (
    .sclk                 (sclk),
    .rst                  (rst),
    .cs_n                 (cs_n),
    .pico                 (pico),
    .control_signal       (control_signal),
    .msg_flag             (msg_flag),
    .trigger_channel_mask (trigger_channel_mask),
    .instruction          (instruction),
    .mode                 (mode),
    .wr_strobe            (wr_strobe),
    .addr_err             (addr_err)
  );

  always #5 sclk = ~sclk;

  function automatic logic [32:0] observed();
    return {control_signal, addr_err, trigger_channel_mask, instruction, mode};
  endfunction

  function automatic logic [32:0] modelled();
    return {m_addr, m_err, m_mask, m_instr, m_mode};
  endfunction

  task automatic model_reset();
    m_mask = MASK_RST; m_instr = INSTR_RST; m_mode = MODE_RST;
    m_addr = 8'd0; m_err = 1'b0; m_wr = 1'b0; m_idx = 0;
    exp_msg = 1'b0; exp_wr = 1'b0;
  endtask

  // One completed byte of a transaction: first byte is address/RW, the rest are data.
  task automatic model_byte(input logic [7:0] b);
    exp_msg = 1'b1;
    exp_wr  = 1'b0;
    if (m_idx == 0) begin
      m_wr   = b[7];
      m_addr = {1'b0, b[6:0]};
    end else begin
      if (m_wr) begin
        if (m_addr == 8'd1) begin m_mask = b; exp_wr = 1'b1; end
        else if (m_addr == 8'd2) begin m_instr = b; exp_wr = 1'b1; end
        else if (m_addr == 8'd3) begin m_mode = b; exp_wr = 1'b1; end
        else m_err = 1'b1;
      end
      m_addr = (m_addr == LAST) ? 8'd1 : m_addr + 8'd1;
    end
    m_idx++;
  endtask

  task automatic drive_bit(input logic b);
    @(negedge sclk);
    cs_n = 1'b0;
    pico = b;
    @(posedge sclk);
    #1;
  endtask

  task automatic idle_edge();
    @(negedge sclk);
    cs_n = 1'b1;
    pico = 1'($urandom);
    @(posedge sclk);
    #1;
    m_idx = 0;
  endtask

  // early collects any strobe seen on the seven edges before byte completion.
  task automatic send_byte(input logic [7:0] b, output logic early, output logic fin_msg,
                           output logic fin_wr);
    early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_bit(b[i]);
      if (i < 7) early = early | msg_flag | wr_strobe;
    end
    fin_msg = msg_flag;
    fin_wr  = wr_strobe;
    model_byte(b);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) drive_bit(b[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; pico = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    model_reset();
    checks++;
    if ({observed(), msg_flag, wr_strobe} !== {modelled(), 2'b00}) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", {observed(), msg_flag, wr_strobe},
               {modelled(), 2'b00});
    end
    @(negedge sclk);
    rst = 1'b0;
    @(posedge sclk);
    #1;
    checks++;
    if ({observed(), msg_flag, wr_strobe} !== {modelled(), 2'b00}) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", {observed(), msg_flag, wr_strobe},
               {modelled(), 2'b00});
    end
    $display("reset: ctrl=%0d mask=%h instr=%h mode=%h", control_signal,
             trigger_channel_mask, instruction, mode);
  endtask

  task automatic test_write();
    logic e, fm, fw;
    idle_edge();
    send_byte(8'h82, e, fm, fw);
    checks++;
    if ({e, fm, fw, control_signal} !== {1'b0, 1'b1, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL write_addr: got early=%b msg=%b wr=%b ctrl=%0d expected 0 1 0 2", e, fm, fw,
               control_signal);
    end
    send_byte(8'hA5, e, fm, fw);
    checks++;
    if ({e, fm, fw, control_signal, instruction} !== {1'b0, 1'b1, 1'b1, 8'd3, 8'hA5}) begin
      errors++;
      $display("FAIL write_data: got early=%b msg=%b wr=%b ctrl=%0d instr=%h expected 0 1 1 3 a5",
               e, fm, fw, control_signal, instruction);
    end
    checks++;
    if (observed() !== modelled()) begin
      errors++;
      $display("FAIL write_state: got %h expected %h", observed(), modelled());
    end
    $display("write: instr=%h ctrl=%0d", instruction, control_signal);
  endtask

  task automatic test_burst_write();
    logic e, fm, fw;
    int strobes;
    logic [7:0] bytes_q[4];
    bytes_q = '{8'h81, 8'h11, 8'h22, 8'h33};
    strobes = 0;
    idle_edge();
    foreach (bytes_q[i]) begin
      send_byte(bytes_q[i], e, fm, fw);
      if (fw === 1'b1) strobes++;
    end
    checks++;
    if ({trigger_channel_mask, instruction, mode, control_signal} !== {8'h11, 8'h22, 8'h33, 8'd4}
        || strobes != 3) begin
      errors++;
      $display("FAIL burst: got mask=%h instr=%h mode=%h ctrl=%0d strobes=%0d expected 11 22 33 4 3",
               trigger_channel_mask, instruction, mode, control_signal, strobes);
    end
    $display("burst: mask=%h instr=%h mode=%h ctrl=%0d", trigger_channel_mask, instruction, mode,
             control_signal);
  endtask

  task automatic test_illegal_write();
    logic e, fm, fw;
    idle_edge();
    send_byte(8'h8A, e, fm, fw);
    send_byte(8'hFF, e, fm, fw);
    checks++;
    if ({addr_err, fw, fm, control_signal} !== {1'b1, 1'b0, 1'b1, 8'd11}
        || observed() !== modelled()) begin
      errors++;
      $display("FAIL illegal: got err=%b wr=%b msg=%b state=%h expected 1 0 1 %h", addr_err, fw,
               fm, observed(), modelled());
    end
    $display("illegal: addr_err=%b ctrl=%0d", addr_err, control_signal);
  endtask

  task automatic test_read_wrap();
    logic e, fm, fw;
    logic [7:0] expected_ctrl[3];
    expected_ctrl = '{8'd59, 8'd1, 8'd2};
    idle_edge();
    for (int i = 0; i < 3; i++) begin
      send_byte((i == 0) ? 8'h3B : 8'($urandom), e, fm, fw);
      checks++;
      if ({control_signal, fm, fw, e} !== {expected_ctrl[i], 1'b1, 1'b0, 1'b0}
          || observed() !== modelled()) begin
        errors++;
        $display("FAIL read_wrap%0d: got ctrl=%0d msg=%b wr=%b early=%b expected ctrl=%0d 1 0 0",
                 i, control_signal, fm, fw, e, expected_ctrl[i]);
      end
      $display("read_wrap: byte %0d ctrl=%0d", i, control_signal);
    end
  endtask

  task automatic test_abort();
    logic e, fm, fw;
    logic [7:0] mode_before;
    idle_edge();
    send_byte(8'h83, e, fm, fw);
    mode_before = m_mode;
    send_partial(8'h5C, 5);
    idle_edge();
    checks++;
    if ({mode, msg_flag, wr_strobe, control_signal} !== {mode_before, 1'b0, 1'b0, 8'd3}) begin
      errors++;
      $display("FAIL abort_hold: got mode=%h msg=%b wr=%b ctrl=%0d expected %h 0 0 3", mode,
               msg_flag, wr_strobe, control_signal, mode_before);
    end
    send_byte(8'h83, e, fm, fw);
    send_byte(8'h0F, e, fm, fw);
    checks++;
    if ({mode, fw, e} !== {8'h0F, 1'b1, 1'b0} || observed() !== modelled()) begin
      errors++;
      $display("FAIL abort_resume: got mode=%h wr=%b early=%b expected 0f 1 0", mode, fw, e);
    end
    $display("abort: mode=%h ctrl=%0d", mode, control_signal);
  endtask

  task automatic test_reset_mid();
    logic e, fm, fw;
    idle_edge();
    send_byte(8'h81, e, fm, fw);
    send_byte(8'hE7, e, fm, fw);
    send_partial(8'hFF, 3);
    #2;
    rst  = 1'b1;
    cs_n = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({observed(), msg_flag, wr_strobe} !== {modelled(), 2'b00}) begin
      errors++;
      $display("FAIL reset_mid: got %h expected %h", {observed(), msg_flag, wr_strobe},
               {modelled(), 2'b00});
    end
    @(negedge sclk);
    rst = 1'b0;
    idle_edge();
    send_byte(8'h82, e, fm, fw);
    send_byte(8'h3C, e, fm, fw);
    checks++;
    if ({instruction, fw} !== {8'h3C, 1'b1} || observed() !== modelled()) begin
      errors++;
      $display("FAIL reset_mid_resume: got %h expected %h", observed(), modelled());
    end
    $display("reset_mid: mask=%h instr=%h", trigger_channel_mask, instruction);
  endtask

  task automatic test_random();
    logic e, fm, fw;
    logic [7:0] a;
    int nbytes;
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 3))
        0:       a = 8'($urandom_range(0, 4));
        1:       a = 8'($urandom_range(56, 60));
        2:       a = 8'($urandom_range(0, 127));
        default: a = 8'($urandom_range(1, 3));
      endcase
      a[7] = 1'($urandom);
      nbytes = $urandom_range(1, 6);
      repeat ($urandom_range(1, 3)) idle_edge();
      for (int b = 0; b < nbytes; b++) begin
        send_byte((b == 0) ? a : 8'($urandom), e, fm, fw);
        checks++;
        if ({e, fm, fw, observed()} !== {1'b0, exp_msg, exp_wr, modelled()}) begin
          errors++;
          $display("FAIL random t%0d b%0d: got %h expected %h", t, b, {e, fm, fw, observed()},
                   {1'b0, exp_msg, exp_wr, modelled()});
        end
      end
      if ($urandom_range(0, 3) == 0) send_partial(8'($urandom), $urandom_range(1, 7));
      $display("random t%0d: addr=%h bytes=%0d ctrl=%0d err=%b", t, a, nbytes, control_signal,
               addr_err);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst_write();
    test_illegal_write();
    test_read_wrap();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
